// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: stall/flush/bubble control for hazards forwarding cannot cover
// (load-use, branch operands compared in ID, multi-cycle mult/div in EX), plus
// saturating stall and flush performance counters.
module hazard_stall_ctrl #(
    parameter int unsigned MD_LATENCY = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       IDRs,
    input  logic [4:0]       IDRt,
    input  logic             IDUsesRt,
    input  logic             IDBranch,
    input  logic             IDTaken,
    input  logic             EXMemRead,
    input  logic             EXRegWrite,
    input  logic [4:0]       EXRd,
    input  logic             EXMDStart,
    input  logic             MEMMemRead,
    input  logic [4:0]       MEMRd,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IFIDFlush,
    output logic             IDEXWrite,
    output logic             IDEXBubble,
    output logic             EXMEMBubble,
    output logic             MDDone,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned MD_W = (MD_LATENCY > 2) ? $clog2(MD_LATENCY) : 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] MD_BUSY = 2'd1;

    // md_cnt counts the remaining freeze cycles after the start cycle
    localparam logic [MD_W-1:0]  MD_INIT = MD_W'(MD_LATENCY - 2);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [MD_W-1:0]  md_cnt;
    logic [MD_W-1:0]  md_cnt_nxt;
    logic [CNT_W-1:0] stall_cnt_nxt;
    logic [CNT_W-1:0] flush_cnt_nxt;

    logic ex_match;
    logic mem_match;
    logic load_use;
    logic br_haz;

    // Source-register match against ID operands; register 0 never matches
    always_comb begin
        ex_match  = (EXRd != 5'd0) &&
                    ((EXRd == IDRs) || (IDUsesRt && (EXRd == IDRt)));
        mem_match = (MEMRd != 5'd0) &&
                    ((MEMRd == IDRs) || (IDUsesRt && (MEMRd == IDRt)));
        load_use  = EXMemRead && ex_match;
        br_haz    = IDBranch && ((EXRegWrite && ex_match) || (MEMMemRead && mem_match));
    end

    // Next-state and same-cycle control outputs; idle values forced while in reset
    always_comb begin
        state_nxt   = state;
        md_cnt_nxt  = md_cnt;
        PCWrite     = 1'b1;
        IFIDWrite   = 1'b1;
        IFIDFlush   = 1'b0;
        IDEXWrite   = 1'b1;
        IDEXBubble  = 1'b0;
        EXMEMBubble = 1'b0;
        MDDone      = 1'b0;

        if (rst) begin
            case (state)
                IDLE: begin
                    if (EXMDStart) begin
                        PCWrite     = 1'b0;
                        IFIDWrite   = 1'b0;
                        IDEXWrite   = 1'b0;
                        EXMEMBubble = 1'b1;
                        state_nxt   = MD_BUSY;
                        md_cnt_nxt  = MD_INIT;
                    end else if (load_use || br_haz) begin
                        // A stalled branch must not flush the instruction behind it yet
                        PCWrite    = 1'b0;
                        IFIDWrite  = 1'b0;
                        IDEXBubble = 1'b1;
                    end else if (IDTaken) begin
                        IFIDFlush = 1'b1;
                    end
                end
                MD_BUSY: begin
                    if (md_cnt != '0) begin
                        PCWrite     = 1'b0;
                        IFIDWrite   = 1'b0;
                        IDEXWrite   = 1'b0;
                        EXMEMBubble = 1'b1;
                        md_cnt_nxt  = md_cnt - MD_W'(1);
                    end else begin
                        MDDone    = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt  = IDLE;
                    md_cnt_nxt = '0;
                end
            endcase
        end
    end

    // Saturating performance counter increments
    always_comb begin
        stall_cnt_nxt = stall_cnt;
        flush_cnt_nxt = flush_cnt;
        if (!PCWrite && (stall_cnt != CNT_MAX)) begin
            stall_cnt_nxt = stall_cnt + CNT_W'(1);
        end
        if (IFIDFlush && (flush_cnt != CNT_MAX)) begin
            flush_cnt_nxt = flush_cnt + CNT_W'(1);
        end
    end

    // State, mult/div countdown and counter registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            md_cnt    <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state     <= state_nxt;
            md_cnt    <= md_cnt_nxt;
            stall_cnt <= stall_cnt_nxt;
            flush_cnt <= flush_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed testbench for hazard_stall_ctrl: default instance plus a CNT_W=4 instance
// for counter saturation, sharing the same stimulus.
module tb_hazard_stall_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] IDRs;
    logic [4:0] IDRt;
    logic       IDUsesRt;
    logic       IDBranch;
    logic       IDTaken;
    logic       EXMemRead;
    logic       EXRegWrite;
    logic [4:0] EXRd;
    logic       EXMDStart;
    logic       MEMMemRead;
    logic [4:0] MEMRd;

    logic        a_pcw, a_ifw, a_iff, a_idw, a_idb, a_exb, a_mdd;
    logic [15:0] a_stall, a_flush;
    logic        b_pcw, b_ifw, b_iff, b_idw, b_idb, b_exb, b_mdd;
    logic [3:0]  b_stall, b_flush;

    // {PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXBubble, EXMEMBubble, MDDone}
    logic [6:0] outs_a;
    logic [6:0] outs_b;
    assign outs_a = {a_pcw, a_ifw, a_iff, a_idw, a_idb, a_exb, a_mdd};
    assign outs_b = {b_pcw, b_ifw, b_iff, b_idw, b_idb, b_exb, b_mdd};

    localparam logic [6:0] IDLE_O   = 7'b1101000;
    localparam logic [6:0] STALL_O  = 7'b0001100;
    localparam logic [6:0] FLUSH_O  = 7'b1111000;
    localparam logic [6:0] FREEZE_O = 7'b0000010;
    localparam logic [6:0] DONE_O   = 7'b1101001;

    int checks;
    int errors;

    hazard_stall_ctrl #(.MD_LATENCY(4), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .IDRs(IDRs), .IDRt(IDRt), .IDUsesRt(IDUsesRt),
        .IDBranch(IDBranch), .IDTaken(IDTaken), .EXMemRead(EXMemRead),
        .EXRegWrite(EXRegWrite), .EXRd(EXRd), .EXMDStart(EXMDStart),
        .MEMMemRead(MEMMemRead), .MEMRd(MEMRd),
        .PCWrite(a_pcw), .IFIDWrite(a_ifw), .IFIDFlush(a_iff), .IDEXWrite(a_idw),
        .IDEXBubble(a_idb), .EXMEMBubble(a_exb), .MDDone(a_mdd),
        .stall_cnt(a_stall), .flush_cnt(a_flush)
    );

    hazard_stall_ctrl #(.MD_LATENCY(4), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .IDRs(IDRs), .IDRt(IDRt), .IDUsesRt(IDUsesRt),
        .IDBranch(IDBranch), .IDTaken(IDTaken), .EXMemRead(EXMemRead),
        .EXRegWrite(EXRegWrite), .EXRd(EXRd), .EXMDStart(EXMDStart),
        .MEMMemRead(MEMMemRead), .MEMRd(MEMRd),
        .PCWrite(b_pcw), .IFIDWrite(b_ifw), .IFIDFlush(b_iff), .IDEXWrite(b_idw),
        .IDEXBubble(b_idb), .EXMEMBubble(b_exb), .MDDone(b_mdd),
        .stall_cnt(b_stall), .flush_cnt(b_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        IDRs = 5'd0; IDRt = 5'd0; IDUsesRt = 1'b0; IDBranch = 1'b0; IDTaken = 1'b0;
        EXMemRead = 1'b0; EXRegWrite = 1'b0; EXRd = 5'd0; EXMDStart = 1'b0;
        MEMMemRead = 1'b0; MEMRd = 5'd0;
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later
    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic do_reset();
        next_cycle();
        clear_inputs();
        rst = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        next_cycle();
        rst = 1'b0;
        EXMemRead = 1'b1; EXRd = 5'd5; IDRs = 5'd5; IDTaken = 1'b1;
        #1;
        checks++;
        if (outs_a !== IDLE_O) begin
            errors++; $display("FAIL reset_outs got=%b exp=%b", outs_a, IDLE_O);
        end
        next_cycle();
        #1;
        checks++;
        if (a_stall !== 16'd0 || a_flush !== 16'd0) begin
            errors++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", a_stall, a_flush);
        end
        clear_inputs();
        rst = 1'b1;
        #1;
        checks++;
        if (outs_a !== IDLE_O) begin
            errors++; $display("FAIL reset_idle got=%b exp=%b", outs_a, IDLE_O);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        EXMemRead = 1'b1; EXRd = 5'd5; IDRs = 5'd5;
        #1;
        checks++;
        if (outs_a !== STALL_O) begin
            errors++; $display("FAIL lu_rs got=%b exp=%b", outs_a, STALL_O);
        end
        next_cycle();
        clear_inputs();
        #1;
        checks++;
        if (outs_a !== IDLE_O || a_stall !== 16'd1) begin
            errors++; $display("FAIL lu_after got=%b cnt=%0d exp=%b cnt=1", outs_a, a_stall, IDLE_O);
        end
        EXMemRead = 1'b1; EXRd = 5'd9; IDRt = 5'd9; IDUsesRt = 1'b1; IDRs = 5'd2;
        #1;
        checks++;
        if (outs_a !== STALL_O) begin
            errors++; $display("FAIL lu_rt got=%b exp=%b", outs_a, STALL_O);
        end
        next_cycle();
        clear_inputs();
        #1;
        checks++;
        if (a_stall !== 16'd2 || a_flush !== 16'd0) begin
            errors++; $display("FAIL lu_cnt got=%0d/%0d exp=2/0", a_stall, a_flush);
        end
    endtask

    task automatic test_no_hazard();
        do_reset();
        EXMemRead = 1'b1; EXRd = 5'd0; IDRs = 5'd0;
        #1;
        checks++;
        if (outs_a !== IDLE_O) begin
            errors++; $display("FAIL nh_r0 got=%b exp=%b", outs_a, IDLE_O);
        end
        next_cycle();
        EXRd = 5'd7; IDRt = 5'd7; IDUsesRt = 1'b0; IDRs = 5'd3;
        #1;
        checks++;
        if (outs_a !== IDLE_O) begin
            errors++; $display("FAIL nh_rt_unused got=%b exp=%b", outs_a, IDLE_O);
        end
        next_cycle();
        clear_inputs();
        EXRegWrite = 1'b1; EXRd = 5'd4; IDRs = 5'd4;
        MEMRd = 5'd4; MEMMemRead = 1'b0;
        #1;
        checks++;
        if (outs_a !== IDLE_O) begin
            errors++; $display("FAIL nh_alu_nonbranch got=%b exp=%b", outs_a, IDLE_O);
        end
        next_cycle();
        clear_inputs();
        #1;
        checks++;
        if (a_stall !== 16'd0) begin
            errors++; $display("FAIL nh_cnt got=%0d exp=0", a_stall);
        end
    endtask

    task automatic test_branch();
        do_reset();
        EXMemRead = 1'b1; EXRegWrite = 1'b1; EXRd = 5'd3;
        IDBranch = 1'b1; IDRs = 5'd3; IDTaken = 1'b1;
        #1;
        checks++;
        if (outs_a !== STALL_O) begin
            errors++; $display("FAIL br_stall1 got=%b exp=%b", outs_a, STALL_O);
        end
        next_cycle();
        EXMemRead = 1'b0; EXRegWrite = 1'b0; EXRd = 5'd0;
        MEMMemRead = 1'b1; MEMRd = 5'd3;
        #1;
        checks++;
        if (outs_a !== STALL_O) begin
            errors++; $display("FAIL br_stall2 got=%b exp=%b", outs_a, STALL_O);
        end
        next_cycle();
        MEMMemRead = 1'b0; MEMRd = 5'd0;
        #1;
        checks++;
        if (outs_a !== FLUSH_O) begin
            errors++; $display("FAIL br_flush got=%b exp=%b", outs_a, FLUSH_O);
        end
        next_cycle();
        clear_inputs();
        #1;
        checks++;
        if (outs_a !== IDLE_O || a_flush !== 16'd1 || a_stall !== 16'd2) begin
            errors++; $display("FAIL br_cnt got=%b %0d/%0d exp=%b 2/1", outs_a, a_stall, a_flush, IDLE_O);
        end
        EXRegWrite = 1'b1; EXRd = 5'd4; IDBranch = 1'b1; IDRt = 5'd4; IDUsesRt = 1'b1;
        #1;
        checks++;
        if (outs_a !== STALL_O) begin
            errors++; $display("FAIL br_alu got=%b exp=%b", outs_a, STALL_O);
        end
        next_cycle();
        clear_inputs();
        IDBranch = 1'b1; IDRs = 5'd6; MEMRd = 5'd6; MEMMemRead = 1'b0; IDTaken = 1'b1;
        #1;
        checks++;
        if (outs_a !== FLUSH_O) begin
            errors++; $display("FAIL br_mem_nonload got=%b exp=%b", outs_a, FLUSH_O);
        end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_muldiv();
        do_reset();
        EXMDStart = 1'b1;
        EXMemRead = 1'b1; EXRd = 5'd8; IDRs = 5'd8; IDTaken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (outs_a !== FREEZE_O) begin
                errors++; $display("FAIL md_freeze%0d got=%b exp=%b", i, outs_a, FREEZE_O);
            end
            next_cycle();
        end
        #1;
        checks++;
        if (outs_a !== DONE_O) begin
            errors++; $display("FAIL md_done got=%b exp=%b", outs_a, DONE_O);
        end
        next_cycle();
        clear_inputs();
        #1;
        checks++;
        if (outs_a !== IDLE_O || a_stall !== 16'd3 || a_flush !== 16'd0) begin
            errors++; $display("FAIL md_after got=%b %0d/%0d exp=%b 3/0", outs_a, a_stall, a_flush, IDLE_O);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid_md();
        do_reset();
        EXMDStart = 1'b1;
        #1;
        checks++;
        if (outs_a !== FREEZE_O) begin
            errors++; $display("FAIL rmd_start got=%b exp=%b", outs_a, FREEZE_O);
        end
        next_cycle();
        EXMDStart = 1'b0;
        next_cycle();
        rst = 1'b0;
        #1;
        checks++;
        if (outs_a !== IDLE_O) begin
            errors++; $display("FAIL rmd_forced got=%b exp=%b", outs_a, IDLE_O);
        end
        next_cycle();
        rst = 1'b1;
        #1;
        checks++;
        if (outs_a !== IDLE_O || a_stall !== 16'd0 || a_flush !== 16'd0) begin
            errors++; $display("FAIL rmd_state got=%b %0d/%0d exp=%b 0/0", outs_a, a_stall, a_flush, IDLE_O);
        end
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            #1;
            checks++;
            if (a_mdd !== 1'b0 || outs_a !== IDLE_O) begin
                errors++; $display("FAIL rmd_nodone%0d got=%b exp=%b", i, outs_a, IDLE_O);
            end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        EXMemRead = 1'b1; EXRd = 5'd12; IDRs = 5'd12;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (i == 14) begin
                checks++;
                if (b_stall !== 4'd14) begin
                    errors++; $display("FAIL sat_pre got=%0d exp=14", b_stall);
                end
            end
            next_cycle();
        end
        #1;
        checks++;
        if (b_stall !== 4'd15 || outs_b !== STALL_O) begin
            errors++; $display("FAIL sat_hold got=%0d %b exp=15 %b", b_stall, outs_b, STALL_O);
        end
        checks++;
        if (a_stall !== 16'd20) begin
            errors++; $display("FAIL sat_wide got=%0d exp=20", a_stall);
        end
        clear_inputs();
        next_cycle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        clear_inputs();
        test_reset();
        test_load_use();
        test_no_hazard();
        test_branch();
        test_muldiv();
        test_reset_mid_md();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
